// File: rtl/tlul_pkg.sv
// Shared TL-UL opcode encodings, GPIO register offsets and byte-mask helper.
package tlul_pkg;

  typedef enum logic [2:0] {
    OP_PUT_FULL    = 3'd0,
    OP_PUT_PARTIAL = 3'd1,
    OP_ARITH       = 3'd2,
    OP_LOGICAL     = 3'd3,
    OP_GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    OP_ACK      = 3'd0,
    OP_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } resp_state_e;

  localparam logic [4:0] REG_DATA_OUT   = 5'h00;
  localparam logic [4:0] REG_DIR        = 5'h04;
  localparam logic [4:0] REG_DATA_IN    = 5'h08;
  localparam logic [4:0] REG_INTR_STATE = 5'h0C;
  localparam logic [4:0] REG_INTR_EN    = 5'h10;

  function automatic logic [31:0] mask_expand(input logic [3:0] mask);
    logic [31:0] w;
    for (int unsigned i = 0; i < 4; i++) begin
      w[i*8 +: 8] = {8{mask[i]}};
    end
    return w;
  endfunction

endpackage

// File: rtl/tlul_gpio_slave_if.sv
// TL-UL channel A/D signal bundle for the GPIO slave.
interface tlul_gpio_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int SRC_WIDTH  = 2
);
  logic                  a_valid;
  logic                  a_ready;
  logic [2:0]            a_opcode;
  logic [2:0]            a_param;
  logic [2:0]            a_size;
  logic [SRC_WIDTH-1:0]  a_source;
  logic [ADDR_WIDTH-1:0] a_address;
  logic [3:0]            a_mask;
  logic [31:0]           a_data;
  logic                  d_valid;
  logic                  d_ready;
  logic [2:0]            d_opcode;
  logic [2:0]            d_param;
  logic [2:0]            d_size;
  logic [SRC_WIDTH-1:0]  d_source;
  logic                  d_sink;
  logic [31:0]           d_data;
  logic                  d_error;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );
endinterface

// File: rtl/tlul_sync2.sv
// Two-flop synchronizer for asynchronous pin inputs.
module tlul_sync2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/tlul_gpio_slave.sv
// TL-UL GPIO slave: 5-register map, synchronized inputs, rising-edge interrupts.
module tlul_gpio_slave
  import tlul_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int SRC_WIDTH  = 2
) (
  input  logic               clk,
  input  logic               reset,
  tlul_gpio_slave_if.slave   tl,
  input  logic [31:0]        gpio_in,
  output logic [31:0]        gpio_out,
  output logic [31:0]        gpio_oe,
  output logic               gpio_intr
);
  resp_state_e          r_state;
  logic [31:0]          r_data_out, r_dir, r_intr_state, r_intr_en, r_sync_q;
  logic                 r_intr;
  logic [2:0]           r_d_opcode, r_d_size;
  logic [SRC_WIDTH-1:0] r_d_source;
  logic [31:0]          r_d_data;
  logic                 r_d_error;

  logic [31:0] w_sync, w_rise, w_wmask, w_clr, w_rdata;
  logic [4:0]  w_off;
  logic        w_accept, w_is_get, w_is_put, w_ack_data, w_err, w_wr;
  logic        w_unused;

  tlul_sync2 #(.WIDTH(32)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (gpio_in),
    .o_q   (w_sync)
  );

  assign w_unused = ^{tl.a_param, tl.a_address[ADDR_WIDTH-1:5]};

  assign w_accept = tl.a_valid & tl.a_ready;
  assign w_off    = tl.a_address[4:0];
  assign w_is_get = (tl.a_opcode == OP_GET);
  assign w_is_put = (tl.a_opcode == OP_PUT_FULL) | (tl.a_opcode == OP_PUT_PARTIAL);
  // Arithmetic/Logical belong to the data-returning class even though they are rejected here.
  assign w_ack_data = w_is_get | (tl.a_opcode == OP_ARITH) | (tl.a_opcode == OP_LOGICAL);

  assign w_err = ~(w_is_get | w_is_put)
               | (tl.a_size > 3'd2)
               | (w_off[1:0] != 2'b00)
               | (w_off > REG_INTR_EN)
               | ((tl.a_opcode == OP_PUT_FULL) & (tl.a_mask != 4'hF))
               | (w_is_put & (w_off == REG_DATA_IN));

  assign w_wr    = w_accept & w_is_put & ~w_err;
  assign w_wmask = mask_expand(tl.a_mask);
  assign w_rise  = w_sync & ~r_sync_q;
  assign w_clr   = (w_wr && w_off == REG_INTR_STATE) ? (tl.a_data & w_wmask) : '0;

  always_comb begin
    w_rdata = '0;
    case (w_off)
      REG_DATA_OUT:   w_rdata = r_data_out;
      REG_DIR:        w_rdata = r_dir;
      REG_DATA_IN:    w_rdata = w_sync;
      REG_INTR_STATE: w_rdata = r_intr_state;
      REG_INTR_EN:    w_rdata = r_intr_en;
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out   <= '0;
      r_dir        <= '0;
      r_intr_state <= '0;
      r_intr_en    <= '0;
      r_sync_q     <= '0;
      r_intr       <= 1'b0;
    end else begin
      r_sync_q     <= w_sync;
      // Edge set is OR'd in after the clear so a coincident edge survives W1C.
      r_intr_state <= (r_intr_state & ~w_clr) | w_rise;
      r_intr       <= |(r_intr_state & r_intr_en);
      if (w_wr) begin
        case (w_off)
          REG_DATA_OUT: r_data_out <= (r_data_out & ~w_wmask) | (tl.a_data & w_wmask);
          REG_DIR:      r_dir      <= (r_dir      & ~w_wmask) | (tl.a_data & w_wmask);
          REG_INTR_EN:  r_intr_en  <= (r_intr_en  & ~w_wmask) | (tl.a_data & w_wmask);
          default:      ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_d_opcode <= '0;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_state    <= ST_RESP;
          r_d_opcode <= w_ack_data ? OP_ACK_DATA : OP_ACK;
          r_d_size   <= tl.a_size;
          r_d_source <= tl.a_source;
          r_d_error  <= w_err;
          r_d_data   <= (w_is_get && !w_err) ? w_rdata : '0;
        end
        ST_RESP: if (tl.d_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tl.a_ready  = (r_state == ST_IDLE);
  assign tl.d_valid  = (r_state == ST_RESP);
  assign tl.d_opcode = r_d_opcode;
  assign tl.d_param  = '0;
  assign tl.d_size   = r_d_size;
  assign tl.d_source = r_d_source;
  assign tl.d_sink   = 1'b0;
  assign tl.d_data   = r_d_data;
  assign tl.d_error  = r_d_error;

  assign gpio_out  = r_data_out;
  assign gpio_oe   = r_dir;
  assign gpio_intr = r_intr;
endmodule

// File: tb/tb_tlul_gpio_slave.sv
// Scoreboard bench for tlul_gpio_slave: directed requests push expected D beats, a monitor pops and compares.
`timescale 1ns/1ps
module tb_tlul_gpio_slave;
  import tlul_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        gpio_intr;

  tlul_gpio_slave_if #(.ADDR_WIDTH(32), .SRC_WIDTH(2)) tl ();

  tlul_gpio_slave #(.ADDR_WIDTH(32), .SRC_WIDTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .tl        (tl),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .gpio_intr (gpio_intr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        err;
    logic [31:0] data;
    logic [1:0]  src;
    logic [2:0]  size;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && tl.d_valid && tl.d_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_d_beat: got d_valid=1 expected no response");
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_opcode"}, 32'(tl.d_opcode), 32'(e.op));
          check({e.name, "_error"},  32'(tl.d_error),  32'(e.err));
          check({e.name, "_data"},   tl.d_data,        e.data);
          check({e.name, "_source"}, 32'(tl.d_source), 32'(e.src));
          check({e.name, "_size"},   32'(tl.d_size),   32'(e.size));
        end
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] op, input logic [4:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input logic [1:0] src,
                       input logic [2:0] size, input logic [2:0] exp_op, input logic exp_err,
                       input logic [31:0] exp_data);
    exp_t e;
    int   i;
    e.name = name; e.op = exp_op; e.err = exp_err; e.data = exp_data; e.src = src; e.size = size;
    exp_q.push_back(e);
    tl.a_valid   = 1'b1;
    tl.a_opcode  = op;
    tl.a_param   = 3'd0;
    tl.a_size    = size;
    tl.a_source  = src;
    tl.a_address = {27'h0, addr};
    tl.a_mask    = mask;
    tl.a_data    = data;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tl.a_ready) break;
    end
    if (i == 50) check({name, "_a_ready_timeout"}, 32'(tl.a_ready), 32'd1);
    @(posedge clk);
    #1;
    tl.a_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (i == 50) check({name, "_d_timeout"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic get(input string name, input logic [4:0] addr, input logic exp_err,
                     input logic [31:0] exp_data);
    issue(name, OP_GET, addr, 4'hF, 32'h0, 2'd1, 3'd2, OP_ACK_DATA, exp_err, exp_data);
    drain(name);
  endtask

  task automatic put(input string name, input logic [2:0] op, input logic [4:0] addr,
                     input logic [3:0] mask, input logic [31:0] data, input logic exp_err);
    issue(name, op, addr, mask, data, 2'd2, 3'd2, OP_ACK, exp_err, 32'h0);
    drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    gpio_in      = '0;
    tl.a_valid   = 1'b0;
    tl.a_opcode  = '0;
    tl.a_param   = '0;
    tl.a_size    = '0;
    tl.a_source  = '0;
    tl.a_address = '0;
    tl.a_mask    = '0;
    tl.a_data    = '0;
    tl.d_ready   = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_a_ready",  32'(tl.a_ready), 32'd1);
    check("rst_d_valid",  32'(tl.d_valid), 32'd0);
    check("rst_d_data",   tl.d_data,       32'h0);
    check("rst_gpio_out", gpio_out,        32'h0);
    check("rst_gpio_oe",  gpio_oe,         32'h0);
    check("rst_intr",     32'(gpio_intr),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    put("put_dout_a5", OP_PUT_FULL, REG_DATA_OUT, 4'hF, 32'h0000_00A5, 1'b0);
    get("get_dout_a5", REG_DATA_OUT, 1'b0, 32'h0000_00A5);
    check("gpio_out_a5", gpio_out, 32'h0000_00A5);

    put("ppart_dir", OP_PUT_PARTIAL, REG_DIR, 4'h2, 32'hFFFF_FFFF, 1'b0);
    check("gpio_oe_ff00", gpio_oe, 32'h0000_FF00);
    put("ppart_dout", OP_PUT_PARTIAL, REG_DATA_OUT, 4'h5, 32'h1122_3344, 1'b0);
    get("get_dout_part", REG_DATA_OUT, 1'b0, 32'h0022_0044);

    put("err_put_datain", OP_PUT_FULL, REG_DATA_IN, 4'hF, 32'hFFFF_FFFF, 1'b1);
    put("err_full_mask", OP_PUT_FULL, REG_DATA_OUT, 4'h3, 32'hFFFF_FFFF, 1'b1);
    put("err_put_0x14", OP_PUT_FULL, 5'h14, 4'hF, 32'hFFFF_FFFF, 1'b1);
    get("err_get_0x14", 5'h14, 1'b1, 32'h0);
    get("err_get_0x02", 5'h02, 1'b1, 32'h0);
    issue("err_opcode2", OP_ARITH, REG_DIR, 4'hF, 32'hFFFF_FFFF, 2'd0, 3'd2, OP_ACK_DATA, 1'b1, 32'h0);
    drain("err_opcode2");
    issue("err_size3", OP_GET, REG_DATA_OUT, 4'hF, 32'h0, 2'd1, 3'd3, OP_ACK_DATA, 1'b1, 32'h0);
    drain("err_size3");
    get("chk_dout_kept", REG_DATA_OUT, 1'b0, 32'h0022_0044);
    get("chk_dir_kept", REG_DIR, 1'b0, 32'h0000_FF00);
    get("chk_ien_kept", REG_INTR_EN, 1'b0, 32'h0);
    check("gpio_out_kept", gpio_out, 32'h0022_0044);
    check("gpio_oe_kept",  gpio_oe,  32'h0000_FF00);

    put("put_ien_8", OP_PUT_FULL, REG_INTR_EN, 4'hF, 32'h8, 1'b0);
    gpio_in[3] = 1'b1;
    repeat (5) @(posedge clk); #1;
    get("get_istate_8", REG_INTR_STATE, 1'b0, 32'h8);
    check("intr_set", 32'(gpio_intr), 32'd1);
    put("w1c_bit3", OP_PUT_FULL, REG_INTR_STATE, 4'hF, 32'h8, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("intr_cleared", 32'(gpio_intr), 32'd0);
    get("get_istate_0", REG_INTR_STATE, 1'b0, 32'h0);

    gpio_in[3] = 1'b0;
    repeat (4) @(posedge clk); #1;
    gpio_in[3] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    issue("w1c_vs_edge", OP_PUT_FULL, REG_INTR_STATE, 4'hF, 32'h8, 2'd2, 3'd2, OP_ACK, 1'b0, 32'h0);
    drain("w1c_vs_edge");
    get("get_istate_setwins", REG_INTR_STATE, 1'b0, 32'h8);

    gpio_in = 32'hCAFE_0000;
    repeat (4) @(posedge clk); #1;
    get("get_datain", REG_DATA_IN, 1'b0, 32'hCAFE_0000);

    tl.d_ready = 1'b0;
    issue("stall_src3", OP_GET, REG_DIR, 4'hF, 32'h0, 2'd3, 3'd2, OP_ACK_DATA, 1'b0, 32'h0000_FF00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_d_valid", 32'(tl.d_valid),  32'd1);
      check("stall_a_ready", 32'(tl.a_ready),  32'd0);
      check("stall_d_src",   32'(tl.d_source), 32'd3);
      check("stall_d_data",  tl.d_data,        32'h0000_FF00);
      check("stall_d_op",    32'(tl.d_opcode), 32'(OP_ACK_DATA));
    end
    @(posedge clk); #1;
    tl.d_ready = 1'b1;
    drain("stall_src3");

    gpio_in = '0;
    repeat (4) @(posedge clk); #1;
    tl.d_ready = 1'b0;
    issue("discarded", OP_GET, REG_DATA_OUT, 4'hF, 32'h0, 2'd1, 3'd2, OP_ACK_DATA, 1'b0, 32'h0022_0044);
    @(negedge clk);
    check("pre_rst_d_valid", 32'(tl.d_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_d_valid", 32'(tl.d_valid), 32'd0);
    check("mid_rst_a_ready", 32'(tl.a_ready), 32'd1);
    check("mid_rst_d_data",  tl.d_data,       32'h0);
    check("mid_rst_out",     gpio_out,        32'h0);
    check("mid_rst_oe",      gpio_oe,         32'h0);
    check("mid_rst_intr",    32'(gpio_intr),  32'd0);
    exp_q.delete();
    tl.d_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk); #1;
    get("post_rst_dout",   REG_DATA_OUT,   1'b0, 32'h0);
    get("post_rst_dir",    REG_DIR,        1'b0, 32'h0);
    get("post_rst_datain", REG_DATA_IN,    1'b0, 32'h0);
    get("post_rst_istate", REG_INTR_STATE, 1'b0, 32'h0);
    get("post_rst_ien",    REG_INTR_EN,    1'b0, 32'h0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tlul_gpio_slave.md
TLUL_GPIO_SLAVE -- requirements
Module: tlul_gpio_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, TL-UL address width.
REQ-002 Parameter SRC_WIDTH, default 2, TL-UL source ID width.
REQ-003 clk  in  1  single clock, the 24 MHz peripheral domain.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 a_valid  in  1  Channel A request valid.
REQ-006 a_ready  out  1  Channel A ready.
REQ-007 a_opcode  in  3  Channel A opcode: PutFullData=0, PutPartialData=1, Get=4.
REQ-008 a_param  in  3  Channel A param; ignored.
REQ-009 a_size  in  3  Channel A log2 byte count.
REQ-010 a_source  in  SRC_WIDTH  Channel A source ID.
REQ-011 a_address  in  ADDR_WIDTH  Channel A byte address; only bits [4:0] are decoded.
REQ-012 a_mask  in  4  Channel A byte-lane mask.
REQ-013 a_data  in  32  Channel A write data.
REQ-014 d_valid  out  1  Channel D response valid.
REQ-015 d_ready  in  1  Channel D ready.
REQ-016 d_opcode  out  3  Channel D opcode: AccessAck=0, AccessAckData=1.
REQ-017 d_param  out  3  Channel D param; always 0.
REQ-018 d_size  out  3  Channel D size; echo of a_size.
REQ-019 d_source  out  SRC_WIDTH  Channel D source; echo of a_source.
REQ-020 d_sink  out  1  Channel D sink; always 0.
REQ-021 d_data  out  32  Channel D read data; 0 unless the response is a successful Get.
REQ-022 d_error  out  1  Channel D error flag.
REQ-023 gpio_in  in  32  asynchronous pin inputs.
REQ-024 gpio_out  out  32  pin output values; equal to the DATA_OUT register.
REQ-025 gpio_oe  out  32  pin output enables; equal to the DIR register.
REQ-026 gpio_intr  out  1  registered level interrupt, equal to |(INTR_STATE & INTR_EN).

Function
REQ-027 The block SHALL implement this register map:
- 0x00 DATA_OUT, read/write.
- 0x04 DIR, read/write.
- 0x08 DATA_IN, read-only; holds the synchronized gpio_in.
- 0x0C INTR_STATE, read / write-1-to-clear.
- 0x10 INTR_EN, read/write.
REQ-028 gpio_in SHALL pass through a 2-flop synchronizer; a rising edge of a synchronized bit SHALL set the matching INTR_STATE bit.
REQ-029 If a rising-edge set and a W1C clear hit the same INTR_STATE bit in the same cycle, the set SHALL win.
REQ-030 One transaction SHALL be outstanding at most; a_ready SHALL equal ~d_valid.
REQ-031 A request is accepted on a_valid&a_ready. The block SHALL drive d_valid=1 on the next cycle and hold all D fields stable until d_valid&d_ready.
REQ-032 A request SHALL be an error if any of the following holds:
- opcode is not 0, 1 or 4;
- a_size > 2;
- a_address[1:0] != 0;
- offset > 0x10;
- PutFullData with a_mask != 4'hF;
- any Put to DATA_IN.
REQ-033 An errored request SHALL have no register side effect, SHALL return d_error=1 and d_data=0, and SHALL return its normal opcode class.
REQ-034 Writes SHALL update only the bytes enabled in a_mask. The register SHALL change on the acceptance edge, and the new value SHALL be visible to the next read.
REQ-035 A Get SHALL capture the read data at the acceptance edge and respond with AccessAckData. A Put SHALL respond with AccessAck.
REQ-036 The block SHALL accept a back-to-back request no earlier than the cycle after the D handshake, giving a throughput of 1 transaction per 2 cycles.

Reset
REQ-037 While reset is high, all registers, synchronizer flops, d_valid, gpio_intr and all D fields SHALL be 0 and a_ready SHALL be 1; gpio_out and gpio_oe follow their registers and are therefore 0.
REQ-038 Reset asserted while a response is pending SHALL discard that response. No D beat SHALL be produced for it after reset is released.

Structure
REQ-039 The TL-UL opcode constants and the register offset constants SHALL live in the shared package tlul_pkg.
REQ-040 The synchronizer SHALL be the sub-module tlul_sync2, instantiated 32 bits wide.

Verification
REQ-041 Put 0x0000_00A5 to 0x00 with mask 0xF, then Get 0x00 -> AccessAck with d_error=0; then AccessAckData 0x0000_00A5, gpio_out=0xA5.
REQ-042 PutPartialData 0xFFFF_FFFF to 0x04 with mask 0x2 -> gpio_oe=0x0000_FF00.
REQ-043 Drive gpio_in bit3 0->1 with INTR_EN=0x8 -> INTR_STATE reads 0x8 and gpio_intr=1; Put 0x8 to 0x0C -> gpio_intr=0. A same-cycle edge and W1C on bit3 -> bit3 remains 1.
REQ-044 Get 0x14, Get 0x02, opcode 2, and Put to 0x08 -> each returns d_error=1 with d_data=0 and leaves registers unchanged.
REQ-045 Hold d_ready=0 for 5 cycles -> D fields stable and a_ready=0 throughout; a_source=3 is echoed on d_source.
REQ-046 Assert reset while d_valid=1 -> d_valid drops, and after reset releases no stale response appears and all registers read 0.
